// File: rtl/dma_axi_multi_csr_pkg.sv
// Shared CSR map, field positions and FSM encoding for the multi-channel
// AXI DMA CSR/dispatch block.
package dma_axi_pkg;

  localparam logic [7:0] CSRA_VERSION  = 8'h20;
  localparam logic [7:0] CSRA_CAPS     = 8'h24;
  localparam logic [7:0] CSRA_CONTROL  = 8'h30;
  localparam logic [7:0] CSRA_IRQ_EN   = 8'h34;
  localparam logic [7:0] CSRA_IRQ_PEND = 8'h38;
  localparam logic [7:0] CSRA_STATUS   = 8'h3C;
  localparam logic [7:0] CSRA_CH_BASE  = 8'h80;
  localparam int         CSRA_CH_STRIDE = 16;

  localparam logic [3:0] CHO_NUM = 4'h0;
  localparam logic [3:0] CHO_SRC = 4'h4;
  localparam logic [3:0] CHO_DST = 4'h8;
  localparam logic [3:0] CHO_CNT = 4'hC;

  localparam int CTRL_EN_BIT   = 31;
  localparam int NUM_GO_BIT    = 31;
  localparam int NUM_ACT_BIT   = 30;
  localparam int NUM_DONE_BIT  = 29;
  localparam int STAT_RUN_BIT  = 31;
  localparam int STAT_BUSY_BIT = 30;
  localparam int STAT_GO_LSB   = 8;

  localparam logic [31:0] DMA_VERSION = 32'h20160301;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [31:0] id_word(input logic [2:0] i);
    case (i)
      3'd0:    id_word = "DMA ";
      3'd1:    id_word = "AXI4";
      3'd2:    id_word = "MULT";
      3'd4:    id_word = "DYNA";
      3'd5:    id_word = "LITH";
      default: id_word = "    ";
    endcase
  endfunction

endpackage

// File: rtl/dma_axi_multi_csr_rr_arb.sv
// Combinational round-robin pick: first request above last_ch, with wrap.
module dma_axi_rr_arb
  import dma_axi_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_WID = 3
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_WID-1:0] last_ch,
  output logic              gnt_vld,
  output logic [CH_WID-1:0] gnt_idx
);

  // Walk farthest-first so the nearest candidate overwrites the rest.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (c == (int'(last_ch) + i) % NUM_CH && req[c]) begin
          gnt_vld = 1'b1;
          gnt_idx = CH_WID'(c);
        end
      end
    end
  end

endmodule

// File: rtl/dma_axi_multi_csr.sv
// Multi-channel DMA CSR file with round-robin dispatch and W1C IRQs.
// Optional per-channel completion counters: DMA_MULTI_CSR_CNT_EN.
module dma_axi_multi_csr
  import dma_axi_pkg::*;
#(
  parameter int T_ADDR_WID = 8,
  parameter int NUM_CH     = 4,
  parameter int CH_WID     = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [T_ADDR_WID-1:0] T_ADDR,
  input  logic                  T_WREN,
  input  logic                  T_RDEN,
  input  logic [31:0]           T_WDATA,
  output logic [31:0]           T_RDATA,
  output logic                  IRQ,
  output logic                  DMA_EN,
  output logic                  DMA_GO,
  output logic [CH_WID-1:0]     DMA_CH,
  input  logic                  DMA_BUSY,
  input  logic                  DMA_DONE,
  output logic [31:0]           DMA_SRC,
  output logic [31:0]           DMA_DST,
  output logic [15:0]           DMA_BNUM,
  output logic [7:0]            DMA_CHUNK
);

  state_t            state;
  logic              en;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] irq_pend;
  logic [NUM_CH-1:0] go;
  logic [NUM_CH-1:0] done;
  logic [7:0]        chunk [NUM_CH];
  logic [15:0]       bnum  [NUM_CH];
  logic [31:0]       src   [NUM_CH];
  logic [31:0]       dst   [NUM_CH];
  logic [CH_WID-1:0] sel;
  logic [CH_WID-1:0] last_ch;

  logic [7:0] a;
  logic [2:0] ch_num;
  logic [3:0] ch_off;
  logic       ch_hit;

  assign a      = 8'(T_ADDR);
  assign ch_num = a[6:4];
  assign ch_off = a[3:0];
  assign ch_hit = (a >= CSRA_CH_BASE) && (int'(ch_num) < NUM_CH);

  logic run, wr_ctrl, en_clr, wr_irq_en, wr_irq_pend, dispatch;
  logic [NUM_CH-1:0] act, wr_num, wr_src, wr_dst, done_ev, ch_sel;

  assign run         = (state == RUN);
  assign wr_ctrl     = T_WREN && (a == CSRA_CONTROL);
  assign en_clr      = wr_ctrl && !T_WDATA[CTRL_EN_BIT];
  assign wr_irq_en   = T_WREN && (a == CSRA_IRQ_EN);
  assign wr_irq_pend = T_WREN && (a == CSRA_IRQ_PEND);

  always_comb begin
    act     = '0;
    ch_sel  = '0;
    wr_num  = '0;
    wr_src  = '0;
    wr_dst  = '0;
    done_ev = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      act[c]    = run && (sel == CH_WID'(c));
      ch_sel[c] = T_WREN && ch_hit && (ch_num == 3'(c));
      wr_num[c] = ch_sel[c] && !act[c] && (ch_off == CHO_NUM);
      wr_src[c] = ch_sel[c] && !act[c] && (ch_off == CHO_SRC);
      wr_dst[c] = ch_sel[c] && !act[c] && (ch_off == CHO_DST);
      // An abort in the same cycle swallows the completion.
      done_ev[c] = act[c] && DMA_DONE && !en_clr;
    end
  end

  logic              gnt_vld;
  logic [CH_WID-1:0] gnt_idx;

  dma_axi_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_WID (CH_WID)
  ) u_arb (
    .req     (go & ~wr_num),
    .last_ch (last_ch),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign dispatch = !run && en && !en_clr && gnt_vld;

  logic [31:0] g_src, g_dst;
  logic [15:0] g_bnum;
  logic [7:0]  g_chunk;

  always_comb begin
    g_src   = '0;
    g_dst   = '0;
    g_bnum  = '0;
    g_chunk = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_idx == CH_WID'(c)) begin
        g_src   = src[c];
        g_dst   = dst[c];
        g_bnum  = bnum[c];
        g_chunk = chunk[c];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      en       <= 1'b0;
      irq_en   <= '0;
      irq_pend <= '0;
      go       <= '0;
      done     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        chunk[c] <= '0;
        bnum[c]  <= '0;
        src[c]   <= '0;
        dst[c]   <= '0;
      end
    end else begin
      if (wr_ctrl)
        en <= T_WDATA[CTRL_EN_BIT];
      if (wr_irq_en)
        irq_en <= T_WDATA[NUM_CH-1:0];
      // Hardware set beats a W1C of the same bit.
      if (wr_irq_pend)
        irq_pend <= (irq_pend & ~T_WDATA[NUM_CH-1:0]) | done_ev;
      else
        irq_pend <= irq_pend | done_ev;
      for (int c = 0; c < NUM_CH; c++) begin
        if (en_clr || done_ev[c])
          go[c] <= 1'b0;
        else if (wr_num[c])
          go[c] <= en & T_WDATA[NUM_GO_BIT];
        if (done_ev[c])
          done[c] <= 1'b1;
        else if (wr_num[c])
          done[c] <= 1'b0;
        if (wr_num[c]) begin
          chunk[c] <= T_WDATA[23:16];
          bnum[c]  <= T_WDATA[15:0];
        end
        if (wr_src[c])
          src[c] <= T_WDATA;
        if (wr_dst[c])
          dst[c] <= T_WDATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      sel       <= '0;
      last_ch   <= CH_WID'(NUM_CH - 1);
      DMA_SRC   <= '0;
      DMA_DST   <= '0;
      DMA_BNUM  <= '0;
      DMA_CHUNK <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dispatch) begin
            state     <= RUN;
            sel       <= gnt_idx;
            DMA_SRC   <= g_src;
            DMA_DST   <= g_dst;
            DMA_BNUM  <= g_bnum;
            DMA_CHUNK <= g_chunk;
          end
        end
        RUN: begin
          if (en_clr) begin
            state <= IDLE;
          end else if (DMA_DONE) begin
            state   <= IDLE;
            last_ch <= sel;
          end
        end
      endcase
    end
  end

  assign DMA_GO = run;
  assign DMA_CH = sel;
  assign DMA_EN = en;
  assign IRQ    = |(irq_pend & irq_en);

`ifdef DMA_MULTI_CSR_CNT_EN
  logic [15:0]       cnt [NUM_CH];
  logic [NUM_CH-1:0] wr_cnt;

  always_comb begin
    wr_cnt = '0;
    for (int c = 0; c < NUM_CH; c++)
      wr_cnt[c] = ch_sel[c] && (ch_off == CHO_CNT);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int c = 0; c < NUM_CH; c++)
        cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_cnt[c])
          cnt[c] <= {15'b0, done_ev[c]};
        else if (done_ev[c])
          cnt[c] <= cnt[c] + 16'd1;
      end
    end
  end
`endif

  logic [31:0] rd, stat, ch_rd;

  always_comb begin
    stat                = '0;
    stat[STAT_RUN_BIT]  = run;
    stat[STAT_BUSY_BIT] = DMA_BUSY;
    stat[STAT_GO_LSB +: NUM_CH] = go;
    stat[CH_WID-1:0]    = sel;
  end

  always_comb begin
    ch_rd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_num == 3'(c)) begin
        unique case (ch_off)
          CHO_NUM: ch_rd = {go[c], act[c], done[c], 5'b0,
                            chunk[c], bnum[c]};
          CHO_SRC: ch_rd = src[c];
          CHO_DST: ch_rd = dst[c];
`ifdef DMA_MULTI_CSR_CNT_EN
          CHO_CNT: ch_rd = {16'b0, cnt[c]};
`endif
          default: ch_rd = '0;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    if (a < CSRA_VERSION) begin
      rd = id_word(a[4:2]);
    end else if (ch_hit) begin
      rd = ch_rd;
    end else begin
      unique case (a)
        CSRA_VERSION:  rd = DMA_VERSION;
        CSRA_CAPS:     rd = {28'b0, 4'(NUM_CH)};
        CSRA_CONTROL:  rd = {en, 31'b0};
        CSRA_IRQ_EN:   rd = 32'(irq_en);
        CSRA_IRQ_PEND: rd = 32'(irq_pend);
        CSRA_STATUS:   rd = stat;
        default:       rd = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N)
      T_RDATA <= '0;
    else if (T_RDEN)
      T_RDATA <= rd;
    else
      T_RDATA <= '0;
  end

endmodule
